// File: rtl/ads869x_spi_responder.sv
// SPI responder emulating an ADS869x ADC with a four-register file.
// Optional build macro ADS869X_RAMP_GEN_EN replaces sample_data with an internal ramp.
`timescale 1ns/1ps

module ads869x_spi_responder #(
    parameter int TCONV      = 665,
    parameter int CLOCK_FREQ = 100
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        RST_n,
    input  logic        SCLK,
    input  logic        CONV,
    input  logic        SDI,
    output logic        SDO,
    input  logic [17:0] sample_data,
    output logic        sample_ack,
    output logic [6:0]  frame_cmd,
    output logic [8:0]  frame_addr,
    output logic [15:0] frame_data,
    output logic        frame_done,
    output logic [15:0] reg_rst_pwrctl,
    output logic [15:0] reg_sdi_ctl,
    output logic [15:0] reg_dataout_ctl,
    output logic [15:0] reg_range_sel,
    output logic        protocol_error
);

    localparam int CONV_CYCLES = (TCONV * CLOCK_FREQ + 999) / 1000;
    localparam int CW          = (CONV_CYCLES < 2) ? 1 : $clog2(CONV_CYCLES + 1);
    localparam logic [CW-1:0] CONV_LOAD = CW'(CONV_CYCLES);

    localparam logic [2:0] RESET_HOLD = 3'd0;
    localparam logic [2:0] IDLE       = 3'd1;
    localparam logic [2:0] CONVERTING = 3'd2;
    localparam logic [2:0] READY      = 3'd3;
    localparam logic [2:0] SHIFTING   = 3'd4;
    localparam logic [2:0] DECODE     = 3'd5;

    localparam logic [6:0] CMD_WRITE = 7'b1101000;
    localparam logic [6:0] CMD_READ  = 7'b1100100;

    localparam logic [8:0] ADDR_RST_PWRCTL  = 9'h004;
    localparam logic [8:0] ADDR_SDI_CTL     = 9'h008;
    localparam logic [8:0] ADDR_DATAOUT_CTL = 9'h010;
    localparam logic [8:0] ADDR_RANGE_SEL   = 9'h014;

    // Pin order in the synchronizer vectors: {RST_n, CONV, SCLK, SDI}
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] sync_d;

    logic           rst_pin_n;
    logic           sdi_s;
    logic           conv_rise;
    logic           conv_fall;
    logic           sclk_rise;
    logic           sclk_fall;

    logic [2:0]     state;
    logic [CW-1:0]  conv_cnt;
    logic           conv_abort;
    logic [31:0]    tx_shift;
    logic [31:0]    rx_shift;
    logic [5:0]     bit_cnt;
    logic           read_pending;
    logic [15:0]    read_value;
    logic [15:0]    lookup_value;
    logic [17:0]    sample_value;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1  <= '0;
            sync2  <= '0;
            sync_d <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value, which is what makes this a real 2-stage chain.
            sync1  <= {RST_n, CONV, SCLK, SDI};
            sync2  <= sync1;
            sync_d <= sync2;
        end
    end

    assign rst_pin_n = sync2[3];
    assign sdi_s     = sync2[0];
    assign conv_rise =  sync2[2] & ~sync_d[2];
    assign conv_fall = ~sync2[2] &  sync_d[2];
    assign sclk_rise =  sync2[1] & ~sync_d[1];
    assign sclk_fall = ~sync2[1] &  sync_d[1];

`ifdef ADS869X_RAMP_GEN_EN
    logic [17:0] ramp;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ramp <= '0;
        end else if (sample_ack) begin
            ramp <= ramp + 18'd1;
        end
    end

    assign sample_value = ramp;
`else
    assign sample_value = sample_data;
`endif

    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        lookup_value = 16'h0000;
        case (rx_shift[24:16])
            ADDR_RST_PWRCTL:  lookup_value = reg_rst_pwrctl;
            ADDR_SDI_CTL:     lookup_value = reg_sdi_ctl;
            ADDR_DATAOUT_CTL: lookup_value = reg_dataout_ctl;
            ADDR_RANGE_SEL:   lookup_value = reg_range_sel;
            default:          lookup_value = 16'h0000;
        endcase
    end

    // The MSB of the TX shifter is live only while bits remain in the frame.
    assign SDO = (state == SHIFTING && bit_cnt != 6'd32) ? tx_shift[31] : 1'b0;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state           <= RESET_HOLD;
            conv_cnt        <= '0;
            conv_abort      <= 1'b0;
            tx_shift        <= '0;
            rx_shift        <= '0;
            bit_cnt         <= '0;
            read_pending    <= 1'b0;
            read_value      <= '0;
            frame_cmd       <= '0;
            frame_addr      <= '0;
            frame_data      <= '0;
            frame_done      <= 1'b0;
            sample_ack      <= 1'b0;
            protocol_error  <= 1'b0;
            reg_rst_pwrctl  <= '0;
            reg_sdi_ctl     <= '0;
            reg_dataout_ctl <= '0;
            reg_range_sel   <= '0;
        end else begin
            sample_ack <= 1'b0;
            frame_done <= 1'b0;
            if (!rst_pin_n) begin
                state           <= RESET_HOLD;
                conv_cnt        <= '0;
                conv_abort      <= 1'b0;
                tx_shift        <= '0;
                bit_cnt         <= '0;
                read_pending    <= 1'b0;
                protocol_error  <= 1'b0;
                reg_rst_pwrctl  <= '0;
                reg_sdi_ctl     <= '0;
                reg_dataout_ctl <= '0;
                reg_range_sel   <= '0;
            end else begin
                case (state)
                    RESET_HOLD: state <= IDLE;

                    IDLE: begin
                        if (conv_rise) begin
                            state    <= CONVERTING;
                            conv_cnt <= CONV_LOAD;
                        end
                    end

                    CONVERTING: begin
                        // An early CONV release aborts the conversion until CONV rises again.
                        if (conv_rise && conv_abort) begin
                            conv_cnt   <= CONV_LOAD;
                            conv_abort <= 1'b0;
                        end else begin
                            if (conv_fall) begin
                                protocol_error <= 1'b1;
                                conv_abort     <= 1'b1;
                            end
                            if (conv_cnt != '0) begin
                                conv_cnt <= conv_cnt - CW'(1);
                            end else if (!conv_abort && !conv_fall) begin
                                state <= READY;
                            end
                        end
                    end

                    READY: begin
                        if (conv_fall) begin
                            state    <= SHIFTING;
                            bit_cnt  <= '0;
                            rx_shift <= '0;
                            if (read_pending) begin
                                tx_shift     <= {read_value, 16'd0};
                                read_pending <= 1'b0;
                            end else begin
                                tx_shift   <= {sample_value, 14'd0};
                                sample_ack <= 1'b1;
                            end
                        end
                    end

                    SHIFTING: begin
                        if (conv_rise) begin
                            state    <= DECODE;
                            conv_cnt <= CONV_LOAD;
                        end else begin
                            if (sclk_rise) begin
                                rx_shift <= {rx_shift[30:0], sdi_s};
                                if (bit_cnt != 6'd32) begin
                                    bit_cnt <= bit_cnt + 6'd1;
                                end
                            end
                            if (sclk_fall) begin
                                tx_shift <= {tx_shift[30:0], 1'b0};
                            end
                        end
                    end

                    DECODE: begin
                        state   <= CONVERTING;
                        bit_cnt <= '0;
                        if (conv_cnt != '0) begin
                            conv_cnt <= conv_cnt - CW'(1);
                        end
                        if (bit_cnt == 6'd32) begin
                            frame_cmd  <= rx_shift[31:25];
                            frame_addr <= rx_shift[24:16];
                            frame_data <= rx_shift[15:0];
                            frame_done <= 1'b1;
                            if (rx_shift[31:25] == CMD_WRITE) begin
                                case (rx_shift[24:16])
                                    ADDR_RST_PWRCTL:  reg_rst_pwrctl  <= rx_shift[15:0];
                                    ADDR_SDI_CTL:     reg_sdi_ctl     <= rx_shift[15:0];
                                    ADDR_DATAOUT_CTL: reg_dataout_ctl <= rx_shift[15:0];
                                    ADDR_RANGE_SEL:   reg_range_sel   <= rx_shift[15:0];
                                    default: ;
                                endcase
                            end else if (rx_shift[31:25] == CMD_READ) begin
                                read_pending <= 1'b1;
                                read_value   <= lookup_value;
                            end
                        end else if (bit_cnt != 6'd0) begin
                            protocol_error <= 1'b1;
                        end
                    end

                    default: state <= RESET_HOLD;
                endcase
            end
        end
    end

endmodule

// File: doc/ads869x_spi_responder.md
ADS869X_SPI_RESPONDER -- requirements
Module: ads869x_spi_responder

Interface
REQ-001 SHALL have parameter TCONV, default 665, minimum conversion time in ns.
REQ-002 SHALL have parameter CLOCK_FREQ, default 100, clock frequency in MHz.
REQ-003 SHALL have port clock, input, 1, single clock for all logic.
REQ-004 SHALL have port reset_n, input, 1, reset: synchronous, active-low.
REQ-005 SHALL have port RST_n, input, 1, device reset pin from the controller; active-low.
REQ-006 SHALL have ports SCLK, CONV and SDI, each input, 1, asynchronous SPI pins driven by the controller.
REQ-007 SHALL have port SDO, output, 1, serial data to the controller.
REQ-008 SHALL have port sample_data, input, 18, conversion value to return.
REQ-009 SHALL have port sample_ack, output, 1, one-cycle pulse when sample_data is latched.
REQ-010 SHALL have ports frame_cmd (7), frame_addr (9) and frame_data (16), outputs, last decoded frame fields.
REQ-011 SHALL have port frame_done, output, 1, one-cycle pulse per decoded frame.
REQ-012 SHALL have ports reg_rst_pwrctl, reg_sdi_ctl, reg_dataout_ctl and reg_range_sel, outputs, 16 each, register file contents.
REQ-013 SHALL have port protocol_error, output, 1, sticky timing or frame violation flag.

Function
REQ-014 SHALL pass SCLK, CONV and SDI through 2-flop synchronizers and use only edges detected after them; SCLK period SHALL be at least 4 clock cycles.
REQ-015 SHALL implement FSM states RESET_HOLD, IDLE, CONVERTING, READY, SHIFTING and DECODE.
REQ-016 SHALL go from any state to RESET_HOLD while synchronized RST_n is low, clear all four registers to 16'h0000 and drive SDO 0; it SHALL enter IDLE on RST_n high.
REQ-017 SHALL go from IDLE or DECODE to CONVERTING on a CONV rise and load a counter with ceil(TCONV*CLOCK_FREQ/1000).
REQ-018 SHALL go from CONVERTING to READY when the counter reaches 0.
REQ-019 SHALL, on a CONV fall in READY, enter SHIFTING, load the 32-bit TX shifter and present its MSB on SDO in the next cycle.
REQ-020 SHALL load the TX shifter with {sample_data,14'd0} and pulse sample_ack, or with {read_value,16'd0} and no sample_ack when a read is pending.
REQ-021 SHALL, in SHIFTING, shift SDI into a 32-bit RX register on each SCLK rise, shift TX on each SCLK fall, and count bits saturating at 32.
REQ-022 SHALL drive SDO 0 once 32 bits have been shifted.
REQ-023 SHALL, on a CONV rise in SHIFTING, enter DECODE and start the next conversion counter in the same cycle.
REQ-024 SHALL, in DECODE with count equal to 32, set frame_cmd=RX[31:25], frame_addr=RX[24:16] and frame_data=RX[15:0], pulse frame_done one cycle, then move to CONVERTING.
REQ-025 SHALL, in DECODE with count between 1 and 31, discard the frame, set protocol_error and issue no frame_done.
REQ-026 SHALL treat count 0 as a silent frame with no decode and no error.
REQ-027 SHALL write frame_data to the register at address 9'h004, 9'h008, 9'h010 or 9'h014 when cmd is 7'b1101000 (WRITE); other addresses SHALL be ignored.
REQ-028 SHALL, for cmd 7'b1100100 (READ), mark read pending with read_value equal to the addressed register (16'h0000 if unmapped); the pending read SHALL be consumed by the next frame.
REQ-029 SHALL treat cmd 7'b0000000 (NOP) and any other cmd as no register action.
REQ-030 SHALL set protocol_error when CONV falls in CONVERTING, remain in CONVERTING and ignore SCLK until the next CONV rise.
REQ-031 SHALL ignore SCLK edges outside SHIFTING.
REQ-032 SHALL hold protocol_error until reset_n or RST_n is asserted.

Reset
REQ-033 SHALL, on reset_n low at a clock edge, enter RESET_HOLD, clear all registers, counters, shifters, frame_* outputs and read-pending, drive SDO, sample_ack, frame_done and protocol_error 0, and clear the synchronizers to 0.
REQ-034 SHALL, on reset mid-frame, drop the frame with no decode.

Configuration
REQ-035 SHALL, with ADS869X_RAMP_GEN_EN defined, ignore sample_data and use an internal 18-bit counter that resets to 0 and increments by 1 on each sample_ack, wrapping 18'h3FFFF to 0; without the macro, sample_data is used.

Verification
REQ-036 SHALL cover: WRITE addr 9'h014 data 16'h0003 -> frame_done pulse, reg_range_sel=16'h0003.
REQ-037 SHALL cover: READ addr 9'h014, then NOP frame -> first 16 SDO bits equal 16'h0003.
REQ-038 SHALL cover: sample_data=18'h2A5A5, CONV high 700 ns, 32-clock frame -> first 18 SDO bits equal 18'h2A5A5, one sample_ack.
REQ-039 SHALL cover: CONV low 300 ns after rising -> protocol_error=1, next frame still served.
REQ-040 SHALL cover: 20-bit frame -> no frame_done, protocol_error=1, registers unchanged.
REQ-041 SHALL cover: RST_n low mid-frame -> all registers 16'h0000, SDO 0; with ADS869X_RAMP_GEN_EN, ramp 18'h3FFFF then 18'h00000.
